cpu_seq_ctrl: RTL

//  Multi-cycle control sequencer for the accumulator datapath (PC, AC, add/sub ALU, PC+1 adder, 4:1 muxes).

---
 rtl/cpu_seq_ctrl_pkg.sv | 33 +++
 rtl/cpu_seq_ctrl_if.sv | 20 ++
 rtl/cpu_seq_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared opcode, state and mux-select encodings for the accumulator sequencer and its datapath.
package cpu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_JMP = 3'b100,
    OP_JZ  = 3'b101,
    OP_NOP = 3'b110,
    OP_HLT = 3'b111
  } opcode_e;

  localparam logic [1:0] PC_SEL_INC  = 2'b00;
  localparam logic [1:0] PC_SEL_JMP  = 2'b01;
  localparam logic [1:0] PC_SEL_HOLD = 2'b10;

  localparam logic [1:0] AC_SEL_ALU = 2'b00;
  localparam logic [1:0] AC_SEL_MEM = 2'b01;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Shared req/ready memory port between the sequencer (master) and the memory arbiter (slave).
interface cpu_seq_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic              addr_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, addr_sel,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, addr_sel,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator datapath.
// Owns the IR and the retired-instruction counter; drives PC/AC mux selects and the memory port.
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int RET_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  cpu_seq_ctrl_if.master    mem,
  input  logic              ac_zero,
  output logic [DATA_W-1:0] ir_q,
  output logic [1:0]        pc_sel,
  output logic [1:0]        ac_sel,
  output logic              ac_load,
  output logic              alu_op,
  output logic              halted,
  output logic [RET_W-1:0]  retired
);

  // Jump target is ir_q[ADDR_W-1:0], so the operand field must fit below the opcode.
  if (ADDR_W != DATA_W - 3) begin : g_bad_addr_w
    $error("ADDR_W must equal DATA_W-3");
  end

  state_e           state_q, state_d;
  logic [RET_W-1:0] retired_q;
  logic             ir_load;
  logic             retire;
  logic             req, we, asel;
  opcode_e          opcode;

  assign opcode = opcode_e'(ir_q[DATA_W-1 -: 3]);

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    we      = 1'b0;
    asel    = 1'b0;
    pc_sel  = PC_SEL_HOLD;
    ac_sel  = AC_SEL_ALU;
    ac_load = 1'b0;
    alu_op  = ALU_ADD;
    halted  = 1'b0;
    ir_load = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          ir_load = 1'b1;
          pc_sel  = PC_SEL_INC;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: state_d = ST_READ;
          OP_STA:                 state_d = ST_WRITE;
          OP_JMP: begin
            pc_sel  = PC_SEL_JMP;
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          OP_JZ: begin
            pc_sel  = ac_zero ? PC_SEL_JMP : PC_SEL_HOLD;
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          OP_NOP: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          OP_HLT: begin
            state_d = ST_HALT;
            retire  = 1'b1;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_READ: begin
        req  = 1'b1;
        asel = 1'b1;
        if (mem.mem_ready) begin
          ac_load = 1'b1;
          ac_sel  = (opcode == OP_LDA) ? AC_SEL_MEM : AC_SEL_ALU;
          alu_op  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_WRITE: begin
        req  = 1'b1;
        we   = 1'b1;
        asel = 1'b1;
        if (mem.mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase

    // Reset overrides everything combinationally so an in-flight request is dropped this cycle.
    if (reset) begin
      state_d = ST_FETCH;
      req     = 1'b0;
      we      = 1'b0;
      asel    = 1'b0;
      pc_sel  = PC_SEL_HOLD;
      ac_sel  = AC_SEL_ALU;
      ac_load = 1'b0;
      alu_op  = ALU_ADD;
      halted  = 1'b0;
      ir_load = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= mem.mem_rdata;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign mem.mem_req  = req;
  assign mem.mem_we   = we;
  assign mem.addr_sel = asel;
  assign retired      = retired_q;

endmodule
